// File: rtl/sdp_nrdma_eg_ctx_pkg.sv
// Shared definitions for the NRDMA egress context consumer: context-entry field
// layout, half-beat mask encodings and the context FSM states.
package sdp_nrdma_eg_ctx_pkg;

    localparam int CTX_PD_W      = 16;
    localparam int LEN_LSB       = 0;
    localparam int LEN_MSB       = 12;
    localparam int LAST_SURF_BIT = 13;
    localparam int ODD_BIT       = 14;

    localparam logic [1:0] MASK_FULL = 2'b11;
    localparam logic [1:0] MASK_HALF = 2'b01;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [LEN_MSB:LEN_LSB] ctx_len_field(input logic [CTX_PD_W-1:0] pd);
        return pd[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/sdp_nrdma_eg_pipe.sv
// One-entry valid/ready output register carrying a tagged read-return beat.
// Contents stay frozen while the entry is valid and not yet taken downstream.
module sdp_nrdma_eg_pipe #(
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_in_vld,
    input  logic [DATA_W-1:0] i_in_pd,
    input  logic [1:0]        i_in_mask,
    input  logic              i_in_last_req,
    input  logic              i_in_last_surf,
    output logic              o_in_rdy,
    output logic              o_out_vld,
    input  logic              i_out_rdy,
    output logic [DATA_W-1:0] o_out_pd,
    output logic [1:0]        o_out_mask,
    output logic              o_out_last_req,
    output logic              o_out_last_surf
);

    logic              r_vld;
    logic [DATA_W-1:0] r_pd;
    logic [1:0]        r_mask;
    logic              r_last_req;
    logic              r_last_surf;

    assign o_in_rdy        = !r_vld || i_out_rdy;
    assign o_out_vld       = r_vld;
    assign o_out_pd        = r_pd;
    assign o_out_mask      = r_mask;
    assign o_out_last_req  = r_last_req;
    assign o_out_last_surf = r_last_surf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld       <= 1'b0;
            r_pd        <= '0;
            r_mask      <= 2'b00;
            r_last_req  <= 1'b0;
            r_last_surf <= 1'b0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end else if (o_in_rdy) begin
            r_vld <= i_in_vld;
            if (i_in_vld) begin
                r_pd        <= i_in_pd;
                r_mask      <= i_in_mask;
                r_last_req  <= i_in_last_req;
                r_last_surf <= i_in_last_surf;
            end
        end
    end

endmodule

// File: rtl/sdp_nrdma_eg_ctx.sv
// NRDMA egress context consumer: pops one context entry per read request and tags
// each returning beat with request-end, half-beat mask and surface-end flags.
module sdp_nrdma_eg_ctx
    import sdp_nrdma_eg_ctx_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 13
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                cq2eg_pvld,
    output logic                cq2eg_prdy,
    input  logic [CTX_PD_W-1:0] cq2eg_pd,
    input  logic                dma_rsp_pvld,
    output logic                dma_rsp_prdy,
    input  logic [DATA_W-1:0]   dma_rsp_pd,
    output logic                eg_out_pvld,
    input  logic                eg_out_prdy,
    output logic [DATA_W-1:0]   eg_out_pd,
    output logic [1:0]          eg_out_mask,
    output logic                eg_out_last_req,
    output logic                eg_out_last_surf,
    output logic                eg_done,
    input  logic                op_abort
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic               r_last_surf;
    logic               r_odd;
    logic               r_done;

    logic               w_ctx_vld;
    logic               w_pipe_rdy;
    logic               w_beat_hs;
    logic               w_final;
    logic               w_pop;
    logic [1:0]         w_mask;
    logic [LEN_MSB:LEN_LSB] w_len_field;

    assign w_ctx_vld   = (r_state == ACTIVE);
    assign w_len_field = ctx_len_field(cq2eg_pd);

    // Beats are only taken with a context loaded, so early returns stall upstream.
    assign dma_rsp_prdy = w_ctx_vld && !op_abort && w_pipe_rdy;
    assign w_beat_hs    = dma_rsp_pvld && dma_rsp_prdy;
    assign w_final      = w_beat_hs && (r_beat_cnt == r_len);
    assign cq2eg_prdy   = !op_abort && (!w_ctx_vld || w_final);
    assign w_pop        = cq2eg_pvld && cq2eg_prdy;
    assign w_mask       = (w_final && r_odd) ? MASK_HALF : MASK_FULL;
    assign eg_done      = r_done;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_last_surf <= 1'b0;
            r_odd       <= 1'b0;
            r_done      <= 1'b0;
        end else if (op_abort) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= eg_out_pvld && eg_out_prdy && eg_out_last_surf;
            if (w_beat_hs) begin
                r_beat_cnt <= w_final ? '0 : r_beat_cnt + 1'b1;
            end
            // A pop in the final-beat cycle reloads the context with no idle bubble.
            if (w_pop) begin
                r_state     <= ACTIVE;
                r_len       <= w_len_field[LEN_W-1:0];
                r_last_surf <= cq2eg_pd[LAST_SURF_BIT];
                r_odd       <= cq2eg_pd[ODD_BIT];
                r_beat_cnt  <= '0;
            end else if (w_final) begin
                r_state <= IDLE;
            end
        end
    end

    sdp_nrdma_eg_pipe #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk             (nvdla_core_clk),
        .rst             (nvdla_core_rst),
        .i_clr           (op_abort),
        .i_in_vld        (w_beat_hs),
        .i_in_pd         (dma_rsp_pd),
        .i_in_mask       (w_mask),
        .i_in_last_req   (w_final),
        .i_in_last_surf  (w_final && r_last_surf),
        .o_in_rdy        (w_pipe_rdy),
        .o_out_vld       (eg_out_pvld),
        .i_out_rdy       (eg_out_prdy),
        .o_out_pd        (eg_out_pd),
        .o_out_mask      (eg_out_mask),
        .o_out_last_req  (eg_out_last_req),
        .o_out_last_surf (eg_out_last_surf)
    );

endmodule

// File: tb/tb_sdp_nrdma_eg_ctx.sv
// Directed bench for sdp_nrdma_eg_ctx: hand-computed expectations checked with
// immediate assertions; one line per transaction.
module tb_sdp_nrdma_eg_ctx;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          cq2eg_pvld;
    logic          cq2eg_prdy;
    logic [15:0]   cq2eg_pd;
    logic          dma_rsp_pvld;
    logic          dma_rsp_prdy;
    logic [DW-1:0] dma_rsp_pd;
    logic          eg_out_pvld;
    logic          eg_out_prdy;
    logic [DW-1:0] eg_out_pd;
    logic [1:0]    eg_out_mask;
    logic          eg_out_last_req;
    logic          eg_out_last_surf;
    logic          eg_done;
    logic          op_abort;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] ctxq[$];

    always #5 clk = ~clk;

    sdp_nrdma_eg_ctx #(.DATA_W(DW), .LEN_W(13)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (rst),
        .cq2eg_pvld       (cq2eg_pvld),
        .cq2eg_prdy       (cq2eg_prdy),
        .cq2eg_pd         (cq2eg_pd),
        .dma_rsp_pvld     (dma_rsp_pvld),
        .dma_rsp_prdy     (dma_rsp_prdy),
        .dma_rsp_pd       (dma_rsp_pd),
        .eg_out_pvld      (eg_out_pvld),
        .eg_out_prdy      (eg_out_prdy),
        .eg_out_pd        (eg_out_pd),
        .eg_out_mask      (eg_out_mask),
        .eg_out_last_req  (eg_out_last_req),
        .eg_out_last_surf (eg_out_last_surf),
        .eg_done          (eg_done),
        .op_abort         (op_abort)
    );

    function automatic logic [DW-1:0] data_of(input int k);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = 32'hA500_0000 + 32'(k * 16 + i);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cq_prdy"},    DW'(cq2eg_prdy),       DW'(1'b1));
        chk({tag, "_rsp_prdy"},   DW'(dma_rsp_prdy),     DW'(1'b0));
        chk({tag, "_pvld"},       DW'(eg_out_pvld),      DW'(1'b0));
        chk({tag, "_pd"},         eg_out_pd,             '0);
        chk({tag, "_mask"},       DW'(eg_out_mask),      DW'(2'b00));
        chk({tag, "_last_req"},   DW'(eg_out_last_req),  DW'(1'b0));
        chk({tag, "_last_surf"},  DW'(eg_out_last_surf), DW'(1'b0));
        chk({tag, "_done"},       DW'(eg_done),          DW'(1'b0));
    endtask

    // Streams n beats (data_of(base+i)) while feeding ctxq; checks every output
    // beat in order against the expected flag vectors.
    task automatic run_beats(input string tag, input int base, input int n,
                             input logic [31:0] lreq_v, input logic [31:0] half_v,
                             input logic [31:0] surf_v, input bit toggle,
                             output logic [31:0] prdy_v, output int span);
        int in_i = 0;
        int out_i = 0;
        int cyc = 0;
        int first_hs = -1;
        int last_hs = -1;
        prdy_v = '0;
        while (out_i < n && cyc < 200) begin
            @(negedge clk);
            eg_out_prdy  = toggle ? (cyc % 2 == 0) : 1'b1;
            dma_rsp_pvld = (in_i < n);
            dma_rsp_pd   = data_of(base + in_i);
            cq2eg_pvld   = (ctxq.size() > 0);
            cq2eg_pd     = (ctxq.size() > 0) ? ctxq[0] : 16'h0;
            #1;
            if (eg_out_pvld) begin
                chk({tag, "_pd"},        eg_out_pd, data_of(base + out_i));
                chk({tag, "_mask"},      DW'(eg_out_mask), DW'(half_v[out_i] ? 2'b01 : 2'b11));
                chk({tag, "_last_req"},  DW'(eg_out_last_req), DW'(lreq_v[out_i]));
                chk({tag, "_last_surf"}, DW'(eg_out_last_surf), DW'(surf_v[out_i]));
                if (eg_out_prdy) begin
                    $display("%s: out beat %0d mask=%b last_req=%b last_surf=%b",
                             tag, out_i, eg_out_mask, eg_out_last_req, eg_out_last_surf);
                    out_i++;
                end
            end
            if (dma_rsp_pvld && dma_rsp_prdy) begin
                prdy_v[in_i] = cq2eg_prdy;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                in_i++;
            end
            if (cq2eg_pvld && cq2eg_prdy) void'(ctxq.pop_front());
            cyc++;
        end
        span = last_hs - first_hs;
        @(negedge clk);
        dma_rsp_pvld = 1'b0;
        cq2eg_pvld   = 1'b0;
        eg_out_prdy  = 1'b1;
        #1;
        chk({tag, "_count"}, DW'(out_i), DW'(n));
        chk({tag, "_no_extra"}, DW'(eg_out_pvld), DW'(1'b0));
    endtask

    initial begin
        logic [31:0] pv;
        int          span;

        rst = 1'b1;
        cq2eg_pvld = 1'b0; cq2eg_pd = '0;
        dma_rsp_pvld = 1'b0; dma_rsp_pd = '0;
        eg_out_prdy = 1'b0; op_abort = 1'b0;

        @(negedge clk); #1;
        chk_reset("reset");
        rst = 1'b0;
        $display("reset: checked reset values");

        // T1: len=0, last_surf=1, single full beat, done pulse
        @(negedge clk);
        cq2eg_pvld = 1'b1; cq2eg_pd = 16'h2000; eg_out_prdy = 1'b1;
        #1 chk("t1_pop_prdy", DW'(cq2eg_prdy), DW'(1'b1));
        @(negedge clk);
        cq2eg_pvld = 1'b0; dma_rsp_pvld = 1'b1; dma_rsp_pd = data_of(100);
        #1;
        chk("t1_rsp_prdy", DW'(dma_rsp_prdy), DW'(1'b1));
        chk("t1_final_cq_prdy", DW'(cq2eg_prdy), DW'(1'b1));
        @(negedge clk);
        dma_rsp_pvld = 1'b0;
        #1;
        chk("t1_pvld", DW'(eg_out_pvld), DW'(1'b1));
        chk("t1_pd", eg_out_pd, data_of(100));
        chk("t1_mask", DW'(eg_out_mask), DW'(2'b11));
        chk("t1_last_req", DW'(eg_out_last_req), DW'(1'b1));
        chk("t1_last_surf", DW'(eg_out_last_surf), DW'(1'b1));
        chk("t1_done_early", DW'(eg_done), DW'(1'b0));
        chk("t1_idle_rsp_prdy", DW'(dma_rsp_prdy), DW'(1'b0));
        @(negedge clk); #1;
        chk("t1_done", DW'(eg_done), DW'(1'b1));
        chk("t1_pvld_clr", DW'(eg_out_pvld), DW'(1'b0));
        @(negedge clk); #1;
        chk("t1_done_pulse", DW'(eg_done), DW'(1'b0));
        $display("t1: single beat surface done");

        // T2: len=3, odd=1, reserved bit set; downstream ready toggling
        ctxq.push_back(16'hC003);
        run_beats("t2", 200, 4, 32'b1000, 32'b1000, 32'b0, 1'b1, pv, span);
        chk("t2_no_done", DW'(eg_done), DW'(1'b0));

        // T4: returns before any entry must stall
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dma_rsp_pvld = 1'b1; dma_rsp_pd = data_of(300);
            #1;
            chk("t4_rsp_stall", DW'(dma_rsp_prdy), DW'(1'b0));
            chk("t4_no_out", DW'(eg_out_pvld), DW'(1'b0));
            $display("t4: early return cycle %0d stalled", i);
        end

        // T3: entries len=1 and len=2 back-to-back, continuing the stalled stream
        ctxq.push_back(16'h0001);
        ctxq.push_back(16'h0002);
        run_beats("t3", 300, 5, 32'b10010, 32'b0, 32'b0, 1'b0, pv, span);
        chk("t3_cq_prdy_vec", DW'(pv[4:0]), DW'(5'b10010));
        chk("t3_no_bubble", DW'(span), DW'(4));

        // T5: abort after beat 2 of a len=7 entry
        @(negedge clk);
        cq2eg_pvld = 1'b1; cq2eg_pd = 16'h0007; eg_out_prdy = 1'b0;
        @(negedge clk);
        cq2eg_pvld = 1'b0; dma_rsp_pvld = 1'b1; dma_rsp_pd = data_of(400);
        #1 chk("t5_beat0_prdy", DW'(dma_rsp_prdy), DW'(1'b1));
        @(negedge clk);
        dma_rsp_pd = data_of(401); eg_out_prdy = 1'b1;
        #1;
        chk("t5_out0", eg_out_pd, data_of(400));
        chk("t5_beat1_prdy", DW'(dma_rsp_prdy), DW'(1'b1));
        @(negedge clk);
        eg_out_prdy = 1'b0; op_abort = 1'b1; dma_rsp_pd = data_of(402);
        #1;
        chk("t5_out1", eg_out_pd, data_of(401));
        chk("t5_abort_rsp_prdy", DW'(dma_rsp_prdy), DW'(1'b0));
        chk("t5_abort_cq_prdy", DW'(cq2eg_prdy), DW'(1'b0));
        @(negedge clk);
        op_abort = 1'b0; dma_rsp_pvld = 1'b0;
        #1;
        chk("t5_pvld_clr", DW'(eg_out_pvld), DW'(1'b0));
        chk("t5_idle_cq_prdy", DW'(cq2eg_prdy), DW'(1'b1));
        chk("t5_idle_rsp_prdy", DW'(dma_rsp_prdy), DW'(1'b0));
        $display("t5: abort cleared state");
        ctxq.push_back(16'h0000);
        run_beats("t5b", 500, 1, 32'b1, 32'b0, 32'b0, 1'b0, pv, span);

        // T6: reset mid-request, then len=1 yields exactly two beats
        @(negedge clk);
        cq2eg_pvld = 1'b1; cq2eg_pd = 16'h2003; eg_out_prdy = 1'b0;
        @(negedge clk);
        cq2eg_pvld = 1'b0; dma_rsp_pvld = 1'b1; dma_rsp_pd = data_of(600);
        @(negedge clk); #1;
        chk("t6_pre_pvld", DW'(eg_out_pvld), DW'(1'b1));
        rst = 1'b1;
        #1 chk_reset("t6_rst");
        @(negedge clk);
        rst = 1'b0; dma_rsp_pvld = 1'b0;
        #1 chk("t6_post_pvld", DW'(eg_out_pvld), DW'(1'b0));
        $display("t6: reset mid-request");
        ctxq.push_back(16'h0001);
        run_beats("t6b", 700, 2, 32'b10, 32'b0, 32'b0, 1'b0, pv, span);
        chk("t6_no_done", DW'(eg_done), DW'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
